// File: rtl/flopoco_fcmp_pipe.sv
// Pipelined multi-mode comparator for FloPoCo floating-point operands.
// Stage 1 captures the operand classification and the raw exp/frac compare,
// middle stages only delay, and the last register holds the resolved result.
module flopoco_fcmp_pipe #(
  parameter int unsigned WE     = 4,
  parameter int unsigned WF     = 3,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WE+WF+2:0]   X,
  input  logic [WE+WF+2:0]   Y,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               result,
  output logic               unordered,
  output logic [WE+WF+2:0]   Z
);

  localparam int unsigned W  = WE + WF + 3;
  localparam int unsigned EF = WE + WF;
  // payload: op, X, Y, class flags X/Y, signs, exp/frac lt and eq
  localparam int unsigned PW = 2 * W + 15;

  logic [STAGES:1] r_v;
  logic [STAGES:0] w_vchain;
  logic [STAGES:1] w_ld;
  logic [PW-1:0]   w_dec;
  logic [PW-1:0]   w_last;
  logic            r_result;
  logic            r_unordered;
  logic [W-1:0]    r_z;

  // Classify both operands and do the unsigned exp/frac compare.
  function automatic logic [PW-1:0] f_decode(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic [2:0]   o);
    logic [3:0] xc;
    logic [3:0] yc;
    logic       lt;
    logic       eq;
    xc = 4'b0001 << x[W-1:W-2];
    yc = 4'b0001 << y[W-1:W-2];
    lt = (x[EF-1:0] < y[EF-1:0]);
    eq = (x[EF-1:0] == y[EF-1:0]);
    return {o, x, y, xc, yc, x[W-3], y[W-3], lt, eq};
  endfunction

  // Position in the numeric order; zero and NaN share the middle slot.
  function automatic logic [2:0] f_rank(input logic [3:0] c, input logic s);
    if (c[2]) return s ? 3'd0 : 3'd4;
    if (c[1]) return s ? 3'd1 : 3'd3;
    return 3'd2;
  endfunction

  // Resolve predicate / min-max selection from a decoded payload.
  function automatic logic [W+1:0] f_resolve(input logic [PW-1:0] p);
    logic [2:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [3:0]   xc;
    logic [3:0]   yc;
    logic         sx;
    logic         sy;
    logic         lt;
    logic         eq;
    logic [2:0]   rx;
    logic [2:0]   ry;
    logic         xlt;
    logic         xeq;
    logic         un;
    logic         bz;
    logic         sel;
    logic         res;
    o  = p[PW-1 -: 3];
    x  = p[PW-4 -: W];
    y  = p[PW-4-W -: W];
    xc = p[11:8];
    yc = p[7:4];
    sx = p[3];
    sy = p[2];
    lt = p[1];
    eq = p[0];
    rx = f_rank(xc, sx);
    ry = f_rank(yc, sy);
    if (rx != ry) begin
      xlt = (rx < ry);
      xeq = 1'b0;
    end else if (xc[1]) begin
      xeq = eq;
      xlt = sx ? (!lt && !eq) : lt;
    end else begin
      xlt = 1'b0;
      xeq = 1'b1;
    end
    un = xc[3] | yc[3];
    // opposite-signed zeros: MIN takes the negative one, MAX the positive one
    bz = xc[0] & yc[0] & (sx ^ sy);
    if (xc[3])      sel = !yc[3];
    else if (yc[3]) sel = 1'b0;
    else if (bz)    sel = o[0] ? sx : sy;
    else if (xeq)   sel = 1'b0;
    else            sel = o[0] ? xlt : !xlt;
    case (o)
      3'b000:  res = !un & xlt;
      3'b001:  res = !un & (xlt | xeq);
      3'b010:  res = !un & xeq;
      3'b011:  res = !un & !xlt & !xeq;
      3'b100:  res = !un & !xlt;
      3'b101:  res = un | !xeq;
      default: res = sel;
    endcase
    return {res, un, (o[2] & o[1] & sel) ? y : x};
  endfunction

  assign w_dec    = f_decode(X, Y, op);
  assign w_vchain = {r_v, in_valid};
  assign in_ready = w_ld[1];

  // Stage k may load when it or any stage below it is empty, or the head drains.
  always_comb begin
    w_ld = '0;
    for (int k = 1; k <= int'(STAGES); k++) begin
      w_ld[k] = out_ready;
      for (int j = k; j <= int'(STAGES); j++) begin
        if (!w_vchain[j]) w_ld[k] = 1'b1;
      end
    end
  end

  // Valid bits advance with the load enables; a stalled stage keeps its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      for (int k = 1; k <= int'(STAGES); k++) begin
        if (w_ld[k]) r_v[k] <= w_vchain[k-1];
      end
    end
  end

  if (STAGES > 1) begin : g_pipe
    logic [PW-1:0] r_p [1:STAGES-1];

    // Decoded payload register followed by plain delay stages.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 1; k <= int'(STAGES) - 1; k++) r_p[k] <= '0;
      end else begin
        if (w_ld[1] & in_valid) r_p[1] <= w_dec;
        for (int k = 2; k <= int'(STAGES) - 1; k++) begin
          if (w_ld[k] & w_vchain[k-1]) r_p[k] <= r_p[k-1];
        end
      end
    end

    assign w_last = r_p[STAGES-1];
  end else begin : g_flat
    assign w_last = w_dec;
  end

  // Output register holds the resolved beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= 1'b0;
      r_unordered <= 1'b0;
      r_z         <= '0;
    end else if (w_ld[STAGES] & w_vchain[STAGES-1]) begin
      {r_result, r_unordered, r_z} <= f_resolve(w_last);
    end
  end

  assign out_valid = r_v[STAGES];
  assign result    = r_result;
  assign unordered = r_unordered;
  assign Z         = r_z;

endmodule

// File: tb/tb_flopoco_fcmp_pipe.sv
// Directed and randomised checks of flopoco_fcmp_pipe across four configurations.
module tb_flopoco_fcmp_pipe;

  localparam logic [9:0] P1  = 10'b01_0_0111_000;  // +1.0
  localparam logic [9:0] P15 = 10'b01_0_0111_100;  // +1.5
  localparam logic [9:0] PZ  = 10'b00_0_0000_000;  // +0
  localparam logic [9:0] NZ  = 10'b00_1_0000_000;  // -0
  localparam logic [9:0] M2  = 10'b01_1_1000_000;  // -2.0
  localparam logic [9:0] M1  = 10'b01_1_0111_000;  // -1.0
  localparam logic [9:0] QN  = 10'b11_0_0000_000;  // NaN
  localparam logic [9:0] PI  = 10'b10_0_0000_000;  // +inf
  localparam logic [9:0] NI  = 10'b10_1_0000_000;  // -inf

  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] sx, sy;
  logic [2:0] sop;
  logic a_iv, a_or, a_ir, a_ov, a_res, a_un;
  logic [9:0] a_z;
  logic b_iv, b_or, b_ir, b_ov, b_res, b_un;
  logic [9:0] b_z;
  logic [33:0] lx, ly;
  logic [2:0] lop;
  logic l_iv, l_or;
  logic c_ir, c_ov, c_res, c_un, d_ir, d_ov, d_res, d_un;
  logic [33:0] c_z, d_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flopoco_fcmp_pipe #(.WE(4), .WF(3), .STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .X(sx), .Y(sy), .op(sop),
    .out_valid(a_ov), .out_ready(a_or), .result(a_res), .unordered(a_un), .Z(a_z));
  flopoco_fcmp_pipe #(.WE(4), .WF(3), .STAGES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .X(sx), .Y(sy), .op(sop),
    .out_valid(b_ov), .out_ready(b_or), .result(b_res), .unordered(b_un), .Z(b_z));
  flopoco_fcmp_pipe #(.WE(8), .WF(23), .STAGES(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(l_iv), .in_ready(c_ir), .X(lx), .Y(ly), .op(lop),
    .out_valid(c_ov), .out_ready(l_or), .result(c_res), .unordered(c_un), .Z(c_z));
  flopoco_fcmp_pipe #(.WE(8), .WF(23), .STAGES(4)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(l_iv), .in_ready(d_ir), .X(lx), .Y(ly), .op(lop),
    .out_valid(d_ov), .out_ready(l_or), .result(d_res), .unordered(d_un), .Z(d_z));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Real value of a FloPoCo operand; infinities map to huge magnitudes.
  function automatic real to_real(input logic [33:0] x, input int we, input int wf);
    logic [1:0] ex;
    longint e, f;
    real m;
    ex = 2'(x >> (we + wf + 1));
    e  = longint'((x >> wf) & ((34'(1) << we) - 34'(1)));
    f  = longint'(x & ((34'(1) << wf) - 34'(1)));
    if (ex == 2'b01)
      m = (2.0 ** (real'(e) - real'((1 << (we - 1)) - 1))) * (1.0 + real'(f) / (2.0 ** wf));
    else if (ex == 2'b10)
      m = 1.0e300;
    else
      m = 0.0;
    return x[we + wf] ? -m : m;
  endfunction

  // Reference model: {result, unordered, Z}.
  function automatic logic [35:0] model(input logic [33:0] x, input logic [33:0] y,
                                        input logic [2:0] o, input int we, input int wf);
    logic [1:0] ex, ey;
    logic xs, ys, un, r, sel;
    real a, b;
    ex = 2'(x >> (we + wf + 1));
    ey = 2'(y >> (we + wf + 1));
    xs = x[we + wf];
    ys = y[we + wf];
    a  = to_real(x, we, wf);
    b  = to_real(y, we, wf);
    un = (ex == 2'b11) || (ey == 2'b11);
    sel = 1'b0;
    case (o)
      3'd0: r = !un && (a < b);
      3'd1: r = !un && (a <= b);
      3'd2: r = !un && (a == b);
      3'd3: r = !un && (a > b);
      3'd4: r = !un && (a >= b);
      3'd5: r = un || (a != b);
      default: begin
        if (ex == 2'b11 && ey == 2'b11) sel = 1'b0;
        else if (ex == 2'b11) sel = 1'b1;
        else if (ey == 2'b11) sel = 1'b0;
        else if (ex == 2'b00 && ey == 2'b00 && xs != ys) sel = (o == 3'd6) ? ys : xs;
        else if (a == b) sel = 1'b0;
        else sel = (o == 3'd6) ? (b < a) : (b > a);
        r = sel;
      end
    endcase
    return {r, un, sel ? y : x};
  endfunction

  function automatic logic [33:0] gen(input int we, input int wf);
    int ef, k;
    logic [1:0] exc;
    logic [33:0] r;
    ef  = we + wf;
    k   = $urandom_range(0, 9);
    exc = (k == 0) ? 2'b00 : (k < 8) ? 2'b01 : (k == 8) ? 2'b10 : 2'b11;
    r   = 34'($urandom) & ((34'(1) << ef) - 34'(1));
    r[ef] = 1'($urandom_range(0, 1));
    return r | (34'(exc) << (ef + 1));
  endfunction

  function automatic logic [33:0] gen_y(input logic [33:0] x, input int we, input int wf);
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return x;
    if (k == 1) return x ^ (34'(1) << (we + wf));
    return gen(we, wf);
  endfunction

  task automatic run_a(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [2:0] o, input logic er, input logic eu, input logic [9:0] ez);
    sx = x; sy = y; sop = o; a_iv = 1'b1;
    chk({tag, "_rdy"}, 64'(a_ir), 64'(1));
    step();
    a_iv = 1'b0;
    step();
    chk(tag, {a_ov, a_res, a_un, a_z}, {1'b1, er, eu, ez});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  sw;
    logic [33:0] bx [0:9];
    logic [33:0] by [0:9];
    logic [2:0]  bo [0:9];
    logic [35:0] bexp [0:9];
    logic [35:0] q [$];
    logic [35:0] e;
    logic [35:0] ec [0:999];
    int occ, sent, got, n;
    logic acc, drn;

    rst_n = 1'b0;
    sx = '0; sy = '0; sop = '0;
    a_iv = 0; a_or = 1; b_iv = 0; b_or = 1;
    lx = '0; ly = '0; lop = '0; l_iv = 0; l_or = 1;
    #3;
    chk("reset_a", {a_ir, a_ov, a_res, a_un, a_z}, {1'b1, 1'b0, 1'b0, 1'b0, 10'd0});
    chk("reset_d", {d_ir, d_ov, d_res, d_un, d_z}, {1'b1, 1'b0, 1'b0, 1'b0, 34'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;

    // predicate sweep, one op per cycle, no bubbles
    sw = 6'b100011;
    sx = P1; sy = P15;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin sop = 3'(i); a_iv = 1'b1; end else a_iv = 1'b0;
      chk("sweep_rdy", 64'(a_ir), 64'(1));
      step();
      if (i == 0) chk("sweep_lat", 64'(a_ov), 64'(0));
      else chk("sweep", {a_ov, a_res, a_un}, {1'b1, sw[i-1], 1'b0});
    end
    step();
    chk("sweep_end", 64'(a_ov), 64'(0));

    run_a("eq_zeros",   NZ, PZ, 3'd2, 1'b1, 1'b0, NZ);
    run_a("min_nz_pz",  NZ, PZ, 3'd6, 1'b0, 1'b0, NZ);
    run_a("min_pz_nz",  PZ, NZ, 3'd6, 1'b1, 1'b0, NZ);
    run_a("max_pz_nz",  PZ, NZ, 3'd7, 1'b0, 1'b0, PZ);
    run_a("lt_neg",     M2, M1, 3'd0, 1'b1, 1'b0, M2);
    run_a("gt_neg",     M2, M1, 3'd3, 1'b0, 1'b0, M2);
    run_a("lt_nan",     QN, PI, 3'd0, 1'b0, 1'b1, QN);
    run_a("ne_nan",     QN, PI, 3'd5, 1'b1, 1'b1, QN);
    run_a("max_nan",    QN, PI, 3'd7, 1'b1, 1'b1, PI);
    run_a("min_ynan",   P1, QN, 3'd6, 1'b0, 1'b1, P1);
    run_a("min_2nan",   QN, QN, 3'd6, 1'b0, 1'b1, QN);
    run_a("le_ninf",    NI, NI, 3'd1, 1'b1, 1'b0, NI);
    run_a("gt_inf",     PI, P15, 3'd3, 1'b1, 1'b0, PI);
    run_a("max_norm",   P15, P1, 3'd7, 1'b0, 1'b0, P15);

    // backpressure on the 3-stage instance
    for (int i = 0; i < 10; i++) begin
      bx[i] = gen(4, 3);
      by[i] = gen_y(bx[i], 4, 3);
      bo[i] = 3'($urandom_range(0, 7));
      bexp[i] = model(bx[i], by[i], bo[i], 4, 3);
    end
    occ = 0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      b_or = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      if (sent < 10) begin
        sx = bx[sent][9:0]; sy = by[sent][9:0]; sop = bo[sent]; b_iv = 1'b1;
      end else b_iv = 1'b0;
      @(negedge clk);
      chk("bp_ready", 64'(b_ir), 64'(!(occ == 3 && !b_or)));
      acc = b_iv & b_ir;
      drn = b_ov & b_or;
      if (drn) begin
        chk("bp_extra", 64'(q.size() > 0), 64'(1));
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("bp_data", {b_res, b_un, b_z}, {e[35], e[34], e[9:0]});
        end
        got++;
      end
      if (acc) begin q.push_back(bexp[sent]); sent++; end
      occ = occ + int'(acc) - int'(drn);
      @(posedge clk); #1;
    end
    chk("bp_count", 64'(got), 64'(10));
    b_iv = 1'b0; b_or = 1'b1;
    repeat (3) step();
    chk("bp_tail", 64'(b_ov), 64'(0));

    // asynchronous reset with two beats in flight
    b_or = 1'b0;
    sx = QN; sy = PI; sop = 3'd5; b_iv = 1'b1;
    step();
    sx = P1; sy = P15; sop = 3'd0;
    step();
    b_iv = 1'b0;
    step();
    chk("rst_pre", {b_ov, b_res, b_un, b_z}, {1'b1, 1'b1, 1'b1, QN});
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {b_ov, b_res, b_un, b_z, b_ir}, {1'b0, 1'b0, 1'b0, 10'd0, 1'b1});
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_or = 1'b1;
    sx = M2; sy = M1; sop = 3'd0; b_iv = 1'b1;
    step();
    b_iv = 1'b0;
    n = 1;
    while (!b_ov && n < 20) begin step(); n++; end
    chk("rst_lat", 64'(n), 64'(3));
    chk("rst_beat", {b_res, b_un, b_z}, {1'b1, 1'b0, M2});

    // single precision random stream, STAGES=1 and STAGES=4 side by side
    for (int i = 0; i < 1003; i++) begin
      if (i < 1000) begin
        lx = gen(8, 23);
        ly = gen_y(lx, 8, 23);
        lop = 3'($urandom_range(0, 7));
        ec[i] = model(lx, ly, lop, 8, 23);
        l_iv = 1'b1;
      end else l_iv = 1'b0;
      step();
      if (i < 1000)
        chk("sp_s1", {c_ir, c_ov, c_res, c_un, c_z}, {1'b1, 1'b1, ec[i]});
      if (i >= 3)
        chk("sp_s4", {d_ir, d_ov, d_res, d_un, d_z}, {1'b1, 1'b1, ec[i-3]});
      else
        chk("sp_s4_lat", 64'(d_ov), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
